// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// opcode/funct fields and the ALU operation codes driven towards the ALU.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  // Opcode field, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Funct field, instruction[5:0], for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000100;
  localparam logic [5:0] FN_SRL = 6'b000110;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1000;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational R-type funct decoder. Kept standalone so a single-cycle
// controller can reuse it unchanged.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  // Map funct to an ALU operation; unknown functs report valid=0
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLL:  alu_op = ALU_SLL;
      FN_SRL:  alu_op = ALU_SRL;
      default: begin
        alu_op = ALU_ADD;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath. Outputs are decoded from
// the current state (PCEn also from Zero in BRANCH); reset forces every
// output low and abandons any partial instruction.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUControl,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_r;
  state_t           next_s;
  logic             retire_s;
  logic [3:0]       funct_op_s;
  logic             funct_valid_s;
  logic [CNT_W-1:0] count_r;

  alu_decoder u_alu_decoder (
    .funct  (Funct),
    .alu_op (funct_op_s),
    .valid  (funct_valid_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= next_s;
  end

  // Retired-instruction counter; reset takes priority over an increment
  always_ff @(posedge clk) begin
    if (reset)         count_r <= {CNT_W{1'b0}};
    else if (retire_s) count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else               count_r <= count_r;
  end

  assign InstrCount = count_r;

  // Next-state and output decode
  always_comb begin
    next_s     = FETCH;
    retire_s   = 1'b0;
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    ALUControl = 4'b0000;
    Illegal    = 1'b0;
    if (reset) begin
      next_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          MemRead    = 1'b1;
          IRWrite    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          PCEn       = 1'b1;
          next_s     = DECODE;
        end
        DECODE: begin
          // Speculatively compute the branch target into ALUOut
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
          case (Opcode)
            OP_RTYPE: begin
              if (funct_valid_s) begin
                next_s = EXEC;
              end else begin
                next_s  = FETCH;
                Illegal = 1'b1;
              end
            end
            OP_LW, OP_SW: next_s = MEMADR;
            OP_BEQ:       next_s = BRANCH;
            OP_J:         next_s = JUMP;
            OP_ADDI:      next_s = ADDI_EX;
            default: begin
              next_s  = FETCH;
              Illegal = 1'b1;
            end
          endcase
        end
        EXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b00;
          ALUControl = funct_op_s;
          next_s     = RTYPE_WB;
        end
        RTYPE_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          retire_s = 1'b1;
          next_s   = FETCH;
        end
        MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          if (Opcode == OP_LW) next_s = MEMRD;
          else                 next_s = MEMWR;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          next_s  = MEMWB;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          retire_s = 1'b1;
          next_s   = FETCH;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire_s = 1'b1;
          next_s   = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b00;
          ALUControl = ALU_SUB;
          PCSource   = 2'b01;
          PCEn       = Zero;
          retire_s   = 1'b1;
          next_s     = FETCH;
        end
        JUMP: begin
          PCSource = 2'b10;
          PCEn     = 1'b1;
          retire_s = 1'b1;
          next_s   = FETCH;
        end
        ADDI_EX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          next_s     = ADDI_WB;
        end
        ADDI_WB: begin
          RegWrite = 1'b1;
          retire_s = 1'b1;
          next_s   = FETCH;
        end
        default: next_s = FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle 32-bit datapath. It sits directly upstream of the ALU.
- Each cycle it drives the 4-bit ALU operation code, operand selects and datapath write strobes, decoded from the latched opcode and funct.
- It consumes the ALU Zero flag to form the PC enable for branches.
- It keeps a retired-instruction counter for lab observation.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- Opcode  in  6  instruction[31:26] from the IR; valid from DECODE onward
- Funct  in  6  instruction[5:0] from the IR
- Zero  in  1  ALU zero flag (combinational from the ALU in the current cycle)
- PCEn  out  1  PC register write enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write-register select: 0 = rt, 1 = rd
- MemtoReg  out  1  write-data select: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = reg A
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUControl  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 0101 SLL, 0110 SRL, 1000 SLT
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- InstrCount  out  CNT_W  number of retired instructions

Behaviour:
- State register: 4 bits, updated on the rising clk edge.
- Outputs are decoded combinationally from the state; PCEn additionally depends on Zero.
- Reset:
  - reset=1 at an edge forces state to FETCH and InstrCount to 0, including mid-instruction; the partial instruction is abandoned.
  - While reset=1, every strobe (PCEn, MemRead, MemWrite, IRWrite, RegWrite, Illegal) is forced to 0.
  - Selects and ALUControl are 0 while reset=1.
- Unlisted outputs are 0 in every state.
- FETCH:
  - MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=00, PCEn=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDI_EX
    - any other opcode -> FETCH with Illegal=1
- R-type funct is checked in DECODE: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000100 SLL (variable, A<<B), 000110 SRL (variable, A>>B). Any other funct -> FETCH with Illegal=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl=decoded funct. Next: RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSource=01, PCEn=Zero. Next: FETCH.
- JUMP: PCSource=10, PCEn=1. Next: FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD. Next: ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- Latency in cycles including FETCH: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- InstrCount:
  - Increments by 1 on the edge leaving RTYPE_WB, MEMWB, MEMWR, BRANCH, JUMP or ADDI_WB.
  - Illegal instructions do not count.
  - Wraps from all-ones to 0.
  - If reset and an increment coincide, reset wins.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11
  - opcode and funct constants
  - the seven ALU operation codes
- One natural sub-module: alu_decoder, purely combinational, mapping Funct to a 4-bit ALUControl plus a valid flag. It is shared with a future single-cycle controller.

Test Plan:
- reset=1 for 2 cycles mid-EXEC -> all strobes 0 during reset, state FETCH next cycle, InstrCount=0.
- R-type funct 100010 (sub) -> states FETCH, DECODE, EXEC, RTYPE_WB; ALUControl=0100 in EXEC; RegWrite=1 and RegDst=1 in RTYPE_WB only; InstrCount +1 after 4 cycles.
- lw then sw -> lw takes 5 cycles with MemRead=1 and IorD=1 in MEMRD and MemtoReg=1 in MEMWB; sw takes 4 cycles with MemWrite=1 in MEMWR; InstrCount=2.
- beq, Zero=1 then Zero=0 -> PCEn=1 then 0 in BRANCH; PCSource=01 and ALUControl=0100 both times; 3 cycles each.
- Opcode 111111, then R-type with funct 111111 -> Illegal=1 for one DECODE cycle each, returns to FETCH, InstrCount unchanged.
- CNT_W=4, 16 jumps from reset -> InstrCount wraps from 15 to 0; PCSource=10 and PCEn=1 in every JUMP state.
